// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the RV32M multiply/divide sequencer.
// Holds the FSM state encoding, the funct3 op codes and the default operand width.
package muldiv_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational radix-2 iteration on operand magnitudes.
// Multiply: shift-add, {acc, lo} holds the growing product, lo[0] is the next
// multiplier bit. Divide (only when MULDIV_DIV_EN is defined): restoring
// shift-subtract, acc holds the partial remainder and lo the dividend/quotient.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
)
(
`ifdef MULDIV_DIV_EN
    input  logic            i_is_div,
`endif
    input  logic [XLEN:0]   i_acc,
    input  logic [XLEN-1:0] i_lo,
    input  logic [XLEN-1:0] i_opb,
    output logic [XLEN:0]   o_acc,
    output logic [XLEN-1:0] o_lo
);

    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_mul_acc;
    logic [XLEN-1:0] w_mul_lo;
`ifdef MULDIV_DIV_EN
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_trial;
`endif

    // Shift-add step: conditionally add the multiplicand, then shift {acc, lo} right.
    always_comb begin
        if (i_lo[0]) begin
            w_sum = i_acc + {1'b0, i_opb};
        end else begin
            w_sum = i_acc;
        end
        w_mul_acc = {1'b0, w_sum[XLEN:1]};
        w_mul_lo  = {w_sum[0], i_lo[XLEN-1:1]};
    end

`ifdef MULDIV_DIV_EN
    // Restoring divide step: shift in the next dividend bit, keep the trial
    // difference only when it did not borrow (bit XLEN clear).
    always_comb begin
        w_shift = {i_acc[XLEN-1:0], i_lo[XLEN-1]};
        w_trial = w_shift - {1'b0, i_opb};
        if (!i_is_div) begin
            o_acc = w_mul_acc;
            o_lo  = w_mul_lo;
        end else if (w_trial[XLEN]) begin
            o_acc = w_shift;
            o_lo  = {i_lo[XLEN-2:0], 1'b0};
        end else begin
            o_acc = w_trial;
            o_lo  = {i_lo[XLEN-2:0], 1'b1};
        end
    end
`else
    // Multiply-only build: the step is always shift-add.
    always_comb begin
        o_acc = w_mul_acc;
        o_lo  = w_mul_lo;
    end
`endif

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide unit for the Execute stage.
// Accepts one M-op, iterates XLEN radix-2 steps in BUSY, applies signs in FIX and
// pulses done_o in DONE while holding the pipeline through stall_o.
// Build option: define MULDIV_DIV_EN to build the divider; without it DIV/REM
// ops complete immediately with result 0 and illegal_o set.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [4:0]      rd_i,
    input  logic            flush_i,
    output logic            ready_o,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o,
    output logic            illegal_o
);

    localparam int                CNT_W  = $clog2(XLEN);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]   ONE_X  = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [2*XLEN-1:0] ONE_2X = {{(2*XLEN-1){1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_f3;
    logic [4:0]        r_rd;
    logic [XLEN:0]     r_acc;
    logic [XLEN-1:0]   r_lo;
    logic [XLEN-1:0]   r_opb;
    logic              r_neg_res;
`ifdef MULDIV_DIV_EN
    logic              r_neg_rem;
    logic              w_div_zero;
    logic              w_div_ovf;
    logic [XLEN-1:0]   w_special;
`endif

    logic              r_done;
    logic [XLEN-1:0]   r_result;
    logic [4:0]        r_rd_o;
    logic              r_illegal;

    logic              w_accept;
    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_neg_a;
    logic              w_neg_b;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic [XLEN:0]     w_step_acc;
    logic [XLEN-1:0]   w_step_lo;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_fix_val;
    logic              w_done_nxt;
    logic              w_res_load;
    logic [XLEN-1:0]   w_res_nxt;
    logic [4:0]        w_rd_nxt;
    logic              w_ill_nxt;

    assign w_accept = valid_i && (r_state == ST_IDLE) && !flush_i;
    assign ready_o  = (r_state == ST_IDLE);
    assign stall_o  = ((r_state == ST_IDLE) && valid_i) || (r_state == ST_BUSY) || (r_state == ST_FIX);
    assign done_o    = r_done;
    assign result_o  = r_result;
    assign rd_o      = r_rd_o;
    assign illegal_o = r_illegal;

    // Operand signedness per op; magnitudes feed the unsigned iteration.
    always_comb begin
        w_a_signed = 1'b0;
        w_b_signed = 1'b0;
        case (funct3_i)
            F3_MUL, F3_MULH, F3_DIV, F3_REM: begin
                w_a_signed = 1'b1;
                w_b_signed = 1'b1;
            end
            F3_MULHSU: begin
                w_a_signed = 1'b1;
                w_b_signed = 1'b0;
            end
            default: begin
                w_a_signed = 1'b0;
                w_b_signed = 1'b0;
            end
        endcase
        w_neg_a = w_a_signed & rs1_i[XLEN-1];
        w_neg_b = w_b_signed & rs2_i[XLEN-1];
        if (w_neg_a) begin
            w_mag_a = ~rs1_i + ONE_X;
        end else begin
            w_mag_a = rs1_i;
        end
        if (w_neg_b) begin
            w_mag_b = ~rs2_i + ONE_X;
        end else begin
            w_mag_b = rs2_i;
        end
    end

`ifdef MULDIV_DIV_EN
    // Divide special cases resolved at accept without iterating.
    always_comb begin
        w_div_zero = (rs2_i == {XLEN{1'b0}});
        w_div_ovf  = ((funct3_i == F3_DIV) || (funct3_i == F3_REM)) &&
                     (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                     (rs2_i == {XLEN{1'b1}});
        if (w_div_zero) begin
            w_special = funct3_i[1] ? rs1_i : {XLEN{1'b1}};
        end else begin
            w_special = funct3_i[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
        end
    end
`endif

    muldiv_step #(.XLEN(XLEN)) u_step (
`ifdef MULDIV_DIV_EN
        .i_is_div (r_f3[2]),
`endif
        .i_acc    (r_acc),
        .i_lo     (r_lo),
        .i_opb    (r_opb),
        .o_acc    (w_step_acc),
        .o_lo     (w_step_lo)
    );

    // Sign fix-up and half/quotient/remainder selection applied in FIX.
    always_comb begin
        w_prod = {r_acc[XLEN-1:0], r_lo};
        if (r_neg_res) begin
            w_prod_fix = ~w_prod + ONE_2X;
        end else begin
            w_prod_fix = w_prod;
        end
        if (r_f3 == F3_MUL) begin
            w_fix_val = w_prod_fix[XLEN-1:0];
        end else begin
            w_fix_val = w_prod_fix[2*XLEN-1:XLEN];
        end
`ifdef MULDIV_DIV_EN
        if (!r_f3[2]) begin
            w_fix_val = w_fix_val;
        end else if (r_f3[1]) begin
            w_fix_val = r_neg_rem ? (~r_acc[XLEN-1:0] + ONE_X) : r_acc[XLEN-1:0];
        end else begin
            w_fix_val = r_neg_res ? (~r_lo + ONE_X) : r_lo;
        end
`endif
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and the values loaded into the registered outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        w_res_load  = 1'b0;
        w_res_nxt   = r_result;
        w_rd_nxt    = r_rd_o;
        w_ill_nxt   = r_illegal;
        case (r_state)
            ST_IDLE: begin
                if (!w_accept) begin
                    w_state_nxt = ST_IDLE;
                end else if (funct3_i[2]) begin
`ifdef MULDIV_DIV_EN
                    if (w_div_zero || w_div_ovf) begin
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = 1'b1;
                        w_res_load  = 1'b1;
                        w_res_nxt   = w_special;
                        w_rd_nxt    = rd_i;
                        w_ill_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = ST_BUSY;
                    end
`else
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                    w_res_load  = 1'b1;
                    w_res_nxt   = {XLEN{1'b0}};
                    w_rd_nxt    = rd_i;
                    w_ill_nxt   = 1'b1;
`endif
                end else begin
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (flush_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_FIX;
                end else begin
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_FIX: begin
                if (flush_i) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                    w_res_load  = 1'b1;
                    w_res_nxt   = w_fix_val;
                    w_rd_nxt    = r_rd;
                    w_ill_nxt   = 1'b0;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Registered outputs: result/rd/illegal hold until the next completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_done    <= 1'b0;
            r_result  <= {XLEN{1'b0}};
            r_rd_o    <= 5'd0;
            r_illegal <= 1'b0;
        end else begin
            r_done <= w_done_nxt;
            if (w_res_load) begin
                r_result  <= w_res_nxt;
                r_rd_o    <= w_rd_nxt;
                r_illegal <= w_ill_nxt;
            end else begin
                r_result  <= r_result;
                r_rd_o    <= r_rd_o;
                r_illegal <= r_illegal;
            end
        end
    end

    // Operand capture at accept and one iteration per BUSY cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= {CNT_W{1'b0}};
            r_f3      <= 3'b000;
            r_rd      <= 5'd0;
            r_acc     <= {(XLEN+1){1'b0}};
            r_lo      <= {XLEN{1'b0}};
            r_opb     <= {XLEN{1'b0}};
            r_neg_res <= 1'b0;
`ifdef MULDIV_DIV_EN
            r_neg_rem <= 1'b0;
`endif
        end else if (w_accept) begin
            r_cnt     <= {CNT_W{1'b0}};
            r_f3      <= funct3_i;
            r_rd      <= rd_i;
            r_acc     <= {(XLEN+1){1'b0}};
            r_lo      <= w_mag_a;
            r_opb     <= w_mag_b;
            r_neg_res <= w_neg_a ^ w_neg_b;
`ifdef MULDIV_DIV_EN
            r_neg_rem <= w_neg_a;
`endif
        end else if ((r_state == ST_BUSY) && !flush_i) begin
            r_cnt <= r_cnt + CNT_ONE;
            r_acc <= w_step_acc;
            r_lo  <= w_step_lo;
        end else begin
            r_cnt <= r_cnt;
            r_acc <= r_acc;
            r_lo  <= r_lo;
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer. Inputs change on the falling
// edge; outputs are sampled on the falling edge. Cycle 0 is the period ending at
// the accept edge; cycle N is N falling edges later.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic [4:0]  rd_i;
    logic        flush_i;
    logic        ready_o;
    logic        stall_o;
    logic        done_o;
    logic [31:0] result_o;
    logic [4:0]  rd_o;
    logic        illegal_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    muldiv_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .valid_i   (valid_i),
        .funct3_i  (funct3_i),
        .rs1_i     (rs1_i),
        .rs2_i     (rs2_i),
        .rd_i      (rd_i),
        .flush_i   (flush_i),
        .ready_o   (ready_o),
        .stall_o   (stall_o),
        .done_o    (done_o),
        .result_o  (result_o),
        .rd_o      (rd_o),
        .illegal_o (illegal_o)
    );

    // Drive one op from a falling edge with the unit idle; report when done_o was
    // seen, the outputs then, and how many cycles stall_o was wrong. Returns on
    // the falling edge after done_o (unit back in IDLE).
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output int cyc, output logic [31:0] res,
                          output logic ill, output logic [4:0] rdo, output int stall_bad);
        int c;
        cyc = -1; res = 32'h0; ill = 1'b0; rdo = 5'd0; stall_bad = 0;
        valid_i = 1'b1; funct3_i = f3; rs1_i = a; rs2_i = b; rd_i = rd;
        #1;
        if (stall_o !== 1'b1) stall_bad++;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0; rs1_i = 32'h0; rs2_i = 32'h0; rd_i = 5'd0;
        c = 1;
        while (c <= 60 && cyc < 0) begin
            if (done_o === 1'b1) begin
                cyc = c; res = result_o; ill = illegal_o; rdo = rd_o;
                if (stall_o !== 1'b0) stall_bad++;
            end else begin
                if (stall_o !== 1'b1) stall_bad++;
                @(negedge clk);
                c++;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        valid_i = 1'b1;
        #1;
        total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL rst_stall_v1: got %b want 1", stall_o); end
        valid_i = 1'b0;
        #1;
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL rst_stall_v0: got %b want 0", stall_o); end
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", ready_o); end
        total++; if (done_o !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done_o); end
        total++; if (result_o !== 32'h0) begin bad++; $display("FAIL rst_result: got %h want 0", result_o); end
        total++; if (rd_o !== 5'd0) begin bad++; $display("FAIL rst_rd: got %0d want 0", rd_o); end
        total++; if (illegal_o !== 1'b0) begin bad++; $display("FAIL rst_illegal: got %b want 0", illegal_o); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mul();
        int cyc; int sb; logic [31:0] res; logic ill; logic [4:0] rdo;
        run_op(3'b000, 32'd7, 32'hFFFFFFFD, 5'd5, cyc, res, ill, rdo, sb);
        total++; if (res !== 32'hFFFFFFEB) begin bad++; $display("FAIL mul_res: got %h want ffffffeb", res); end
        total++; if (cyc != 34) begin bad++; $display("FAIL mul_cycle: got %0d want 34", cyc); end
        total++; if (sb != 0) begin bad++; $display("FAIL mul_stall: got %0d bad cycles want 0", sb); end
        total++; if (rdo !== 5'd5) begin bad++; $display("FAIL mul_rd: got %0d want 5", rdo); end
        total++; if (ill !== 1'b0) begin bad++; $display("FAIL mul_ill: got %b want 0", ill); end
        total++; if (done_o !== 1'b0 || ready_o !== 1'b1) begin bad++; $display("FAIL mul_after: got done=%b ready=%b want 0 1", done_o, ready_o); end
        run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, cyc, res, ill, rdo, sb);
        total++; if (res !== 32'hFFFFFFFE) begin bad++; $display("FAIL mulhu_res: got %h want fffffffe", res); end
        run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, cyc, res, ill, rdo, sb);
        total++; if (res !== 32'h00000000) begin bad++; $display("FAIL mulh_res: got %h want 00000000", res); end
        run_op(3'b010, 32'hFFFFFFFF, 32'h00000002, 5'd8, cyc, res, ill, rdo, sb);
        total++; if (res !== 32'hFFFFFFFF) begin bad++; $display("FAIL mulhsu_res: got %h want ffffffff", res); end
        run_op(3'b001, 32'h80000000, 32'h80000000, 5'd9, cyc, res, ill, rdo, sb);
        total++; if (res !== 32'h40000000) begin bad++; $display("FAIL mulh_min: got %h want 40000000", res); end
        run_op(3'b000, 32'h12345678, 32'h00000010, 5'd10, cyc, res, ill, rdo, sb);
        total++; if (res !== 32'h23456780) begin bad++; $display("FAIL mul_lo: got %h want 23456780", res); end
    endtask

    task automatic test_back_to_back();
        int cyc; int sb; logic [31:0] res; logic ill; logic [4:0] rdo;
        run_op(3'b011, 32'h80000000, 32'h00000002, 5'd11, cyc, res, ill, rdo, sb);
        total++; if (res !== 32'h00000001) begin bad++; $display("FAIL b2b_first: got %h want 00000001", res); end
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL b2b_ready: got %b want 1", ready_o); end
        run_op(3'b000, 32'd3, 32'd4, 5'd12, cyc, res, ill, rdo, sb);
        total++; if (res !== 32'd12 || ill !== 1'b0) begin bad++; $display("FAIL b2b_second: got %h ill=%b want 0000000c ill=0", res, ill); end
        total++; if (cyc != 34 || rdo !== 5'd12) begin bad++; $display("FAIL b2b_timing: got cyc=%0d rd=%0d want 34 12", cyc, rdo); end
    endtask

`ifdef MULDIV_DIV_EN
    task automatic test_div();
        int cyc; int sb; logic [31:0] res; logic ill; logic [4:0] rdo;
        run_op(3'b100, 32'hFFFFFFF9, 32'd2, 5'd1, cyc, res, ill, rdo, sb);
        total++; if (res !== 32'hFFFFFFFD || cyc != 34) begin bad++; $display("FAIL div_neg: got %h cyc=%0d want fffffffd 34", res, cyc); end
        run_op(3'b110, 32'hFFFFFFF9, 32'd2, 5'd2, cyc, res, ill, rdo, sb);
        total++; if (res !== 32'hFFFFFFFF) begin bad++; $display("FAIL rem_neg: got %h want ffffffff", res); end
        run_op(3'b101, 32'd100, 32'd7, 5'd3, cyc, res, ill, rdo, sb);
        total++; if (res !== 32'd14 || ill !== 1'b0) begin bad++; $display("FAIL divu: got %h ill=%b want 0000000e 0", res, ill); end
        run_op(3'b111, 32'd100, 32'd7, 5'd4, cyc, res, ill, rdo, sb);
        total++; if (res !== 32'd2) begin bad++; $display("FAIL remu: got %h want 00000002", res); end
        run_op(3'b101, 32'd9, 32'd0, 5'd13, cyc, res, ill, rdo, sb);
        total++; if (res !== 32'hFFFFFFFF || cyc != 1) begin bad++; $display("FAIL divu_zero: got %h cyc=%0d want ffffffff 1", res, cyc); end
        total++; if (rdo !== 5'd13 || sb != 0) begin bad++; $display("FAIL divu_zero_rd: got rd=%0d stallbad=%0d want 13 0", rdo, sb); end
        run_op(3'b110, 32'd5, 32'd0, 5'd14, cyc, res, ill, rdo, sb);
        total++; if (res !== 32'd5 || cyc != 1) begin bad++; $display("FAIL rem_zero: got %h cyc=%0d want 00000005 1", res, cyc); end
        run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd15, cyc, res, ill, rdo, sb);
        total++; if (res !== 32'h80000000 || cyc != 1) begin bad++; $display("FAIL div_ovf: got %h cyc=%0d want 80000000 1", res, cyc); end
        run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd16, cyc, res, ill, rdo, sb);
        total++; if (res !== 32'h0 || cyc != 1) begin bad++; $display("FAIL rem_ovf: got %h cyc=%0d want 00000000 1", res, cyc); end
    endtask
`else
    task automatic test_illegal();
        int cyc; int sb; logic [31:0] res; logic ill; logic [4:0] rdo;
        run_op(3'b100, 32'd8, 32'd2, 5'd17, cyc, res, ill, rdo, sb);
        total++; if (cyc != 1) begin bad++; $display("FAIL ill_cycle: got %0d want 1", cyc); end
        total++; if (res !== 32'h0) begin bad++; $display("FAIL ill_res: got %h want 00000000", res); end
        total++; if (ill !== 1'b1) begin bad++; $display("FAIL ill_flag: got %b want 1", ill); end
        total++; if (rdo !== 5'd17 || sb != 0) begin bad++; $display("FAIL ill_rd: got rd=%0d stallbad=%0d want 17 0", rdo, sb); end
        run_op(3'b111, 32'd100, 32'd7, 5'd18, cyc, res, ill, rdo, sb);
        total++; if (ill !== 1'b1 || cyc != 1) begin bad++; $display("FAIL ill_remu: got ill=%b cyc=%0d want 1 1", ill, cyc); end
        run_op(3'b000, 32'd3, 32'd4, 5'd19, cyc, res, ill, rdo, sb);
        total++; if (res !== 32'd12 || ill !== 1'b0) begin bad++; $display("FAIL ill_mul: got %h ill=%b want 0000000c 0", res, ill); end
    endtask
`endif

    task automatic test_flush();
        int seen;
        logic [31:0] prev;
        prev = result_o;
        valid_i = 1'b1; funct3_i = 3'b000; rs1_i = 32'd5; rs2_i = 32'd6; rd_i = 5'd20;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        for (int c = 1; c < 10; c++) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL flush_ready: got %b want 1", ready_o); end
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL flush_stall: got %b want 0", stall_o); end
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (done_o === 1'b1) seen++;
            @(negedge clk);
        end
        total++; if (seen != 0) begin bad++; $display("FAIL flush_done: got %0d pulses want 0", seen); end
        total++; if (result_o !== prev) begin bad++; $display("FAIL flush_hold: got %h want %h", result_o, prev); end
        valid_i = 1'b1; flush_i = 1'b1;
        @(negedge clk);
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL flush_noaccept: got ready=%b want 1", ready_o); end
        valid_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int cyc; int sb; logic [31:0] res; logic ill; logic [4:0] rdo;
        valid_i = 1'b1; funct3_i = 3'b000; rs1_i = 32'd9; rs2_i = 32'd9; rd_i = 5'd21;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        for (int c = 1; c < 20; c++) @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (done_o !== 1'b0 || illegal_o !== 1'b0) begin bad++; $display("FAIL mid_rst_flags: got done=%b ill=%b want 0 0", done_o, illegal_o); end
        total++; if (result_o !== 32'h0) begin bad++; $display("FAIL mid_rst_result: got %h want 00000000", result_o); end
        total++; if (rd_o !== 5'd0) begin bad++; $display("FAIL mid_rst_rd: got %0d want 0", rd_o); end
        total++; if (ready_o !== 1'b1 || stall_o !== 1'b0) begin bad++; $display("FAIL mid_rst_hs: got ready=%b stall=%b want 1 0", ready_o, stall_o); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_op(3'b000, 32'd3, 32'd4, 5'd22, cyc, res, ill, rdo, sb);
        total++; if (res !== 32'd12 || cyc != 34) begin bad++; $display("FAIL mid_rst_next: got %h cyc=%0d want 0000000c 34", res, cyc); end
    endtask

    initial begin
        rst = 1'b0; valid_i = 1'b0; funct3_i = 3'b000; rs1_i = 32'h0; rs2_i = 32'h0;
        rd_i = 5'd0; flush_i = 1'b0;
        test_reset();
        test_mul();
        test_back_to_back();
`ifdef MULDIV_DIV_EN
        test_div();
`else
        test_illegal();
`endif
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
